// File: rtl/interval_timer_arbiter_if.sv
// Avalon-MM write-only view of the shared Interval Timer s1 slave, plus its interrupt line.
interface interval_timer_arbiter_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic        irq;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  irq
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output irq
  );
endinterface

// File: rtl/interval_timer_arbiter.sv
// Round-robin arbiter that lends one Interval Timer to NUM_CH requesters for one-shot delays:
// programs the period, starts the timer, waits for irq (or a cancel) and hands back done.
module interval_timer_arbiter #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned PERIOD_W = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_CH-1:0]          req_valid,
  input  logic [NUM_CH*PERIOD_W-1:0] req_period,
  output logic [NUM_CH-1:0]          grant,
  output logic [NUM_CH-1:0]          done,
  output logic                       busy,
  interval_timer_arbiter_if.master   tmr
);

  localparam int unsigned ChW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [2:0]  AddrStatus = 3'd0;
  localparam logic [2:0]  AddrCtrl   = 3'd1;
  localparam logic [2:0]  AddrPl     = 3'd2;
  localparam logic [2:0]  AddrPh     = 3'd3;
  localparam logic [15:0] CtrlStop   = 16'h0008;
  localparam logic [15:0] CtrlStart  = 16'h0005;

  typedef enum logic [3:0] {
    StIdle, StStop, StPl, StPh, StClr, StStart, StWait, StAck, StAbort, StAbrtClr
  } state_e;

  state_e              state_q;
  logic [ChW-1:0]      ch_q;
  logic [ChW-1:0]      rr_q;
  logic [PERIOD_W-1:0] period_q;

  logic [PERIOD_W-1:0] period_arr [NUM_CH];
  logic [PERIOD_W-1:0] pick_period;
  logic                pick_found;
  logic [ChW-1:0]      pick_idx;
  logic [ChW-1:0]      cand;
  logic [ChW-1:0]      ch_next;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_period
    assign period_arr[g] = req_period[g*PERIOD_W +: PERIOD_W];
  end

  // First requesting channel at or after the round-robin pointer, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      cand = ChW'((32'(rr_q) + k) % NUM_CH);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign pick_period = period_arr[pick_idx];
  assign ch_next     = (ch_q == ChW'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      ch_q           <= '0;
      rr_q           <= '0;
      period_q       <= '0;
      grant          <= '0;
      done           <= '0;
      busy           <= 1'b0;
      tmr.chipselect <= 1'b0;
      tmr.write_n    <= 1'b1;
      tmr.address    <= AddrStatus;
      tmr.writedata  <= '0;
    end else begin
      // Bus idles unless the state being entered issues a write.
      done           <= '0;
      tmr.chipselect <= 1'b0;
      tmr.write_n    <= 1'b1;
      tmr.address    <= AddrStatus;
      tmr.writedata  <= '0;
      unique case (state_q)
        StIdle: begin
          if (pick_found) begin
            ch_q            <= pick_idx;
            period_q        <= (pick_period == '0) ? PERIOD_W'(1) : pick_period;
            grant           <= '0;
            grant[pick_idx] <= 1'b1;
            busy            <= 1'b1;
            tmr.chipselect  <= 1'b1;
            tmr.write_n     <= 1'b0;
            tmr.address     <= AddrCtrl;
            tmr.writedata   <= CtrlStop;
            state_q         <= StStop;
          end
        end
        StStop: begin
          tmr.chipselect <= 1'b1;
          tmr.write_n    <= 1'b0;
          tmr.address    <= AddrPl;
          tmr.writedata  <= period_q[15:0];
          state_q        <= StPl;
        end
        StPl: begin
          tmr.chipselect <= 1'b1;
          tmr.write_n    <= 1'b0;
          tmr.address    <= AddrPh;
          tmr.writedata  <= period_q[PERIOD_W-1:16];
          state_q        <= StPh;
        end
        StPh: begin
          tmr.chipselect <= 1'b1;
          tmr.write_n    <= 1'b0;
          tmr.address    <= AddrStatus;
          tmr.writedata  <= '0;
          state_q        <= StClr;
        end
        StClr: begin
          tmr.chipselect <= 1'b1;
          tmr.write_n    <= 1'b0;
          tmr.address    <= AddrCtrl;
          tmr.writedata  <= CtrlStart;
          state_q        <= StStart;
        end
        StStart: state_q <= StWait;
        StWait: begin
          // irq takes priority over a simultaneous cancel.
          if (tmr.irq) begin
            done[ch_q]     <= 1'b1;
            grant          <= '0;
            rr_q           <= ch_next;
            tmr.chipselect <= 1'b1;
            tmr.write_n    <= 1'b0;
            tmr.address    <= AddrStatus;
            tmr.writedata  <= '0;
            state_q        <= StAck;
          end else if (!req_valid[ch_q]) begin
            grant          <= '0;
            rr_q           <= ch_next;
            tmr.chipselect <= 1'b1;
            tmr.write_n    <= 1'b0;
            tmr.address    <= AddrCtrl;
            tmr.writedata  <= CtrlStop;
            state_q        <= StAbort;
          end
        end
        StAck: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        StAbort: begin
          tmr.chipselect <= 1'b1;
          tmr.write_n    <= 1'b0;
          tmr.address    <= AddrStatus;
          tmr.writedata  <= '0;
          state_q        <= StAbrtClr;
        end
        StAbrtClr: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          grant   <= '0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interval_timer_arbiter.sv
// Scoreboard bench for interval_timer_arbiter with a behavioural timer and round-robin model.
module tb_interval_timer_arbiter;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*32-1:0] req_period = '0;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           busy;

  interval_timer_arbiter_if tmr_bus ();

  interval_timer_arbiter #(.NUM_CH(N), .PERIOD_W(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_period (req_period),
    .grant      (grant),
    .done       (done),
    .busy       (busy),
    .tmr        (tmr_bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Timer model: one-shot; delay shortened to period[7:0]+2 cycles to keep runs brief.
  logic        tm_to, tm_ito, tm_run;
  logic [15:0] tm_pl, tm_ph;
  int          tm_cnt;
  assign tmr_bus.irq = tm_to & tm_ito;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tm_to <= 1'b0; tm_ito <= 1'b0; tm_run <= 1'b0;
      tm_pl <= '0;   tm_ph <= '0;    tm_cnt <= 0;
    end else if (tmr_bus.chipselect && !tmr_bus.write_n) begin
      case (tmr_bus.address)
        3'd0: tm_to <= 1'b0;
        3'd1: begin
          tm_ito <= tmr_bus.writedata[0];
          if (tmr_bus.writedata[3]) tm_run <= 1'b0;
          if (tmr_bus.writedata[2]) begin
            tm_run <= 1'b1;
            tm_cnt <= 32'(tm_pl[7:0]) + 2;
          end
        end
        3'd2: tm_pl <= tmr_bus.writedata;
        3'd3: tm_ph <= tmr_bus.writedata;
        default: ;
      endcase
    end else if (tm_run) begin
      if (tm_cnt <= 1) begin
        tm_to  <= 1'b1;
        tm_run <= 1'b0;
      end else begin
        tm_cnt <= tm_cnt - 1;
      end
    end
  end

  typedef struct packed {
    logic [2:0]  addr;
    logic [15:0] data;
    logic        b2b;
  } wr_t;

  wr_t exp_wr[$];
  int  exp_grant[$];
  int  exp_done[$];
  int  n_checks = 0;
  int  n_fail = 0;
  bit  sb_en = 1'b1;
  int  model_rr = 0;
  int  last_wr_cyc = -10;
  int  last_start_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: DUT output with nothing expected (cycle %0d)", name, cyc);
  endtask

  // Write monitor
  always @(negedge clk) begin
    wr_t e;
    if (reset_n && sb_en && tmr_bus.chipselect) begin
      check("wr_strobe", 32'(tmr_bus.write_n), 32'd0);
      if (exp_wr.size() == 0) begin
        unexpected("wr_unexpected");
      end else begin
        e = exp_wr.pop_front();
        check("wr_addr", 32'(tmr_bus.address), 32'(e.addr));
        check("wr_data", 32'(tmr_bus.writedata), 32'(e.data));
        if (e.b2b) check("wr_back_to_back", 32'(cyc - last_wr_cyc), 32'd1);
      end
      if (tmr_bus.address == 3'd1 && tmr_bus.writedata == 16'h0005) last_start_cyc = cyc;
      last_wr_cyc = cyc;
    end
  end

  // Grant and done monitors
  logic [N-1:0] prev_grant = '0;
  logic         prev_irq = 1'b0;
  always @(negedge clk) begin
    int g;
    if (reset_n && sb_en && grant != '0 && prev_grant == '0) begin
      if (exp_grant.size() == 0) unexpected("grant_unexpected");
      else begin
        g = exp_grant.pop_front();
        check("grant", 32'(grant), 32'(1) << g);
        check("busy_while_granted", 32'(busy), 32'd1);
      end
    end
    if (reset_n && sb_en && done != '0) begin
      if (exp_done.size() == 0) unexpected("done_unexpected");
      else begin
        g = exp_done.pop_front();
        check("done", 32'(done), 32'(1) << g);
        check("done_after_irq", 32'(prev_irq), 32'd1);
        check("grant_off_at_done", 32'(grant), 32'd0);
      end
    end
    prev_grant = grant;
    prev_irq   = tmr_bus.irq;
  end

  // Reference model: round-robin choice from the pending set
  function automatic int pick(input logic [N-1:0] m);
    for (int k = 0; k < N; k++) begin
      if (m[(model_rr + k) % N]) return (model_rr + k) % N;
    end
    return -1;
  endfunction

  task automatic push_slot(input int ch, input logic [31:0] p, input bit abort);
    logic [31:0] pe;
    pe = (p == 32'd0) ? 32'd1 : p;
    exp_grant.push_back(ch);
    exp_wr.push_back({3'd1, 16'h0008, 1'b0});
    exp_wr.push_back({3'd2, pe[15:0], 1'b1});
    exp_wr.push_back({3'd3, pe[31:16], 1'b1});
    exp_wr.push_back({3'd0, 16'h0000, 1'b1});
    exp_wr.push_back({3'd1, 16'h0005, 1'b1});
    if (abort) begin
      exp_wr.push_back({3'd1, 16'h0008, 1'b0});
      exp_wr.push_back({3'd0, 16'h0000, 1'b1});
    end else begin
      exp_wr.push_back({3'd0, 16'h0000, 1'b0});
      exp_done.push_back(ch);
    end
    model_rr = (ch + 1) % N;
  endtask

  task automatic wait_dones(input int n, input bit drop);
    int seen = 0;
    int t = 0;
    while (seen < n && t < 3000) begin
      @(negedge clk);
      t++;
      if (done != '0) begin
        seen++;
        if (drop) req_valid = req_valid & ~done;
        else if (seen == n) req_valid = '0;
      end
    end
    if (seen < n) begin
      req_valid = '0;
      check("done_timeout", 32'(seen), 32'(n));
    end
  endtask

  task automatic wait_quiet();
    int t = 0;
    while ((busy || exp_wr.size() != 0 || exp_done.size() != 0 || exp_grant.size() != 0)
           && t < 600) begin
      @(negedge clk);
      t++;
    end
    check("scoreboard_drained", 32'(exp_wr.size() + exp_done.size() + exp_grant.size()), 32'd0);
    check("idle_after_drain", 32'(busy), 32'd0);
    exp_wr.delete();
    exp_done.delete();
    exp_grant.delete();
  endtask

  // Every channel in mask requests at once and drops on its done.
  task automatic serve(input logic [N-1:0] mask, input logic [N*32-1:0] per);
    logic [N-1:0] m;
    int c;
    m = mask;
    while (m != '0) begin
      c = pick(m);
      push_slot(c, per[c*32 +: 32], 1'b0);
      m[c] = 1'b0;
    end
    @(negedge clk);
    req_period = per;
    req_valid  = mask;
    wait_dones($countones(mask), 1'b1);
    wait_quiet();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_grant"}, 32'(grant), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_cs"}, 32'(tmr_bus.chipselect), 32'd0);
    check({tag, "_write_n"}, 32'(tmr_bus.write_n), 32'd1);
    check({tag, "_addr"}, 32'(tmr_bus.address), 32'd0);
    check({tag, "_wdata"}, 32'(tmr_bus.writedata), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N*32-1:0] per;
    logic [N-1:0]    m;
    int c1;
    int c2;
    int t;
    int req_cyc;

    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // All four held: 0,1,2,3,0
    per = {32'd6, 32'd4, 32'd9, 32'd3};
    m = '1;
    for (int i = 0; i < 5; i++) push_slot(pick(m), per[pick(m)*32 +: 32], 1'b0);
    req_period = per;
    req_valid  = '1;
    wait_dones(5, 1'b0);
    wait_quiet();

    // ch0 with period 0x0001_0010 and request-to-START latency
    per = '0;
    per[31:0] = 32'h0001_0010;
    push_slot(pick(4'b0001), per[31:0], 1'b0);
    @(negedge clk);
    req_period = per;
    req_valid  = 4'b0001;
    req_cyc    = cyc;
    wait_dones(1, 1'b1);
    wait_quiet();
    check("req_to_start_latency", 32'(last_start_cyc - req_cyc), 32'd5);

    // ch1 cancelled in WAIT, ch2 served next
    per = '0;
    per[63:32] = 32'h0000_0080;
    per[95:64] = 32'h0002_0007;
    c1 = pick(4'b0110);
    push_slot(c1, per[c1*32 +: 32], 1'b1);
    c2 = pick(4'b0110 & ~(4'b0001 << c1));
    push_slot(c2, per[c2*32 +: 32], 1'b0);
    @(negedge clk);
    req_period = per;
    req_valid  = 4'b0110;
    t = 0;
    while (!(tmr_bus.chipselect && tmr_bus.address == 3'd1 && tmr_bus.writedata == 16'h0005)
           && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("cancel_start_seen", 32'(t < 100), 32'd1);
    repeat (3) @(negedge clk);
    req_valid[c1] = 1'b0;
    wait_dones(1, 1'b1);
    wait_quiet();

    // ch2 period 0 clamps to 1
    per = '0;
    serve(4'b0100, per);

    // ch3 drops in the same cycle irq is seen
    per = '0;
    per[127:96] = 32'd10;
    push_slot(pick(4'b1000), per[127:96], 1'b0);
    @(negedge clk);
    req_period = per;
    req_valid  = 4'b1000;
    t = 0;
    while (!tmr_bus.irq && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("irq_seen", 32'(tmr_bus.irq), 32'd1);
    req_valid[3] = 1'b0;
    wait_dones(1, 1'b0);
    wait_quiet();

    // Random batches
    for (int r = 0; r < 8; r++) begin
      m = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        per[i*32 +: 32] = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 40));
      end
      serve(m, per);
    end

    // Park rr at 3, then reset mid-PH write
    per = '0;
    per[95:64] = 32'd3;
    serve(4'b0100, per);
    sb_en = 1'b0;
    per[127:96] = 32'd80;
    req_period = per;
    req_valid  = 4'b1000;
    t = 0;
    while (!(tmr_bus.chipselect && tmr_bus.address == 3'd3) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("ph_write_seen", 32'(t < 100), 32'd1);
    reset_n   = 1'b0;
    req_valid = '0;
    @(negedge clk);
    check_reset_vals("midreset");
    reset_n  = 1'b1;
    model_rr = 0;
    @(negedge clk);
    sb_en = 1'b1;
    per = '0;
    per[63:32]  = 32'd5;
    per[127:96] = 32'd2;
    serve(4'b1010, per);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
